seq_mult_acc: RTL and testbench

//  Parametrised sequential shift-add multiplier/accumulator; next generation of the 8-bit

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_addsub.sv | 18 +
 rtl/seq_mult_acc.sv | 117 +++++++++++
 tb/tb_seq_mult_acc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier/accumulator.
// Holds the control state encoding and the iteration-counter width rule.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index W iterations; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_addsub.sv
// (W+1)-bit adder/subtractor that combines the extended multiplicand with {X,A}.
// The multiplicand is sign- or zero-extended depending on the operating mode.
module mult_addsub #(
  parameter int W = 8
) (
  input  logic [W:0]   xa_i,
  input  logic [W-1:0] s_i,
  input  logic         signed_i,
  input  logic         sub_i,
  output logic [W:0]   sum_o
);

  logic [W:0] ext;

  assign ext   = signed_i ? {s_i[W-1], s_i} : {1'b0, s_i};
  assign sum_o = sub_i ? (xa_i - ext) : (xa_i + ext);

endmodule

// File: rtl/seq_mult_acc.sv
// Sequential shift-add multiplier/accumulator: one multiplier bit per clock,
// signed or unsigned, optionally adding the previous A as an addend.
module seq_mult_acc
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           Clk_i,
  input  logic           Reset_i,
  input  logic [W-1:0]   Din_i,
  input  logic           Load_B_i,
  input  logic           Run_i,
  input  logic           Signed_Mode_i,
  input  logic           Accum_i,
  output logic [W-1:0]   Aval_o,
  output logic [W-1:0]   Bval_o,
  output logic           Xval_o,
  output logic [2*W-1:0] Product_o,
  output logic           Busy_o,
  output logic           Done_o
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     s_q;
  logic             x_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             signed_q;
  logic             busy_q;
  logic             done_q;

  logic             start_d;
  logic [W:0]       sum_d;
  logic [W:0]       step_d;

  assign start_d = (state_q == IDLE) && Run_i && !run_q;

  // The final multiplier bit carries negative weight in two's complement, hence subtract.
  mult_addsub #(.W(W)) u_addsub (
    .xa_i     ({x_q, a_q}),
    .s_i      (s_q),
    .signed_i (signed_q),
    .sub_i    (signed_q && (cnt_q == LAST)),
    .sum_o    (sum_d)
  );

  assign step_d = b_q[0] ? sum_d : {x_q, a_q};

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      x_q      <= 1'b0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      run_q <= Run_i;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            s_q      <= Din_i;
            signed_q <= Signed_Mode_i;
            cnt_q    <= '0;
            x_q      <= (Signed_Mode_i && Accum_i) ? a_q[W-1] : 1'b0;
            if (!Accum_i) a_q <= '0;
            state_q  <= RUN;
            busy_q   <= 1'b1;
          end else if (Load_B_i) begin
            b_q <= Din_i;
          end
        end
        RUN: begin
          // Add and arithmetic/logical shift of {X,A,B} happen in the same cycle.
          x_q   <= signed_q ? step_d[W] : 1'b0;
          a_q   <= step_d[W:1];
          b_q   <= {step_d[0], b_q[W-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (Load_B_i) b_q <= Din_i;
          if (!Run_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Aval_o    = a_q;
  assign Bval_o    = b_q;
  assign Xval_o    = x_q;
  assign Product_o = {a_q, b_q};
  assign Busy_o    = busy_q;
  assign Done_o    = done_q;

endmodule

// File: tb/tb_seq_mult_acc.sv
// Self-checking bench for seq_mult_acc (W=8): directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_mult_acc;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           loadB;
  logic           run;
  logic           signedMode;
  logic           accum;
  logic [W-1:0]   aval;
  logic [W-1:0]   bval;
  logic           xval;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;

  // Model of the architectural A and B registers.
  logic [W-1:0] mA = '0;
  logic [W-1:0] mB = '0;

  seq_mult_acc #(.W(W)) dut (
    .Clk_i         (clk),
    .Reset_i       (rst_n),
    .Din_i         (din),
    .Load_B_i      (loadB),
    .Run_i         (run),
    .Signed_Mode_i (signedMode),
    .Accum_i       (accum),
    .Aval_o        (aval),
    .Bval_o        (bval),
    .Xval_o        (xval),
    .Product_o     (product),
    .Busy_o        (busy),
    .Done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   b;
    logic [W-1:0]   s;
    bit             sm;
    bit             acc;
    logic [2*W-1:0] prod;
    bit             x;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result = addend + S*B with the addend being the previous A (sign-
  // extended in signed mode), truncated to 2W bits.
  function automatic logic [2*W-1:0] modelProduct(input logic [W-1:0] aPrev, input logic [W-1:0] bv,
                                                   input logic [W-1:0] sv, input bit sm, input bit acc);
    int res;
    if (sm) res = (acc ? int'($signed(aPrev)) : 0) + int'($signed(sv)) * int'($signed(bv));
    else    res = (acc ? int'(aPrev) : 0) + int'(sv) * int'(bv);
    return res[2*W-1:0];
  endfunction

  task automatic loadBReg(input logic [W-1:0] v);
    @(negedge clk);
    din   = v;
    loadB = 1'b1;
    @(negedge clk);
    loadB = 1'b0;
    mB    = v;
  endtask

  // Runs one operation; disturb toggles inputs during RUN, lbStart asserts Load_B
  // with the start edge, holdCycles keeps Run high after DONE.
  task automatic applyStimulus(input logic [W-1:0] s, input bit sm, input bit acc,
                               input logic [2*W-1:0] expProd, input bit expX,
                               input bit disturb, input bit lbStart, input int holdCycles);
    int cycles;
    @(negedge clk);
    din        = s;
    signedMode = sm;
    accum      = acc;
    loadB      = lbStart;
    run        = 1'b1;
    cycles     = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) checkOutput("busy_in_run", {31'd0, busy}, 32'd1);
      if (!done) begin
        @(negedge clk);
        loadB = disturb ? 1'($urandom) : 1'b0;
        if (disturb) begin
          din        = W'($urandom);
          signedMode = 1'($urandom);
          accum      = 1'($urandom);
        end
      end
    end while (!done && cycles < 4 * W);
    loadB = 1'b0;
    checkOutput("done_latency", cycles, W + 1);
    checkOutput("product", {16'd0, product}, {16'd0, expProd});
    checkOutput("aval", {24'd0, aval}, {24'd0, expProd[2*W-1:W]});
    checkOutput("xval", {31'd0, xval}, {31'd0, expX});
    mA = expProd[2*W-1:W];
    mB = expProd[W-1:0];
    if (holdCycles > 0) begin
      repeat (holdCycles) @(posedge clk);
      #1;
      checkOutput("done_held", {30'd0, done, busy}, 32'd2);
      checkOutput("product_held", {16'd0, product}, {16'd0, expProd});
    end
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_after_release", {30'd0, done, busy}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [W-1:0]   s;
    logic [W-1:0]   b;
    bit             sm;
    bit             acc;
    logic [2*W-1:0] exp;

    vecs[0] = '{b: 8'hC5, s: 8'h07, sm: 1'b1, acc: 1'b0, prod: 16'hFE63, x: 1'b1};
    vecs[1] = '{b: 8'h02, s: 8'h03, sm: 1'b1, acc: 1'b1, prod: 16'h0004, x: 1'b0};
    vecs[2] = '{b: 8'hC5, s: 8'h07, sm: 1'b0, acc: 1'b0, prod: 16'h0563, x: 1'b0};
    vecs[3] = '{b: 8'h80, s: 8'h80, sm: 1'b1, acc: 1'b0, prod: 16'h4000, x: 1'b0};
    vecs[4] = '{b: 8'h80, s: 8'h80, sm: 1'b0, acc: 1'b0, prod: 16'h4000, x: 1'b0};
    vecs[5] = '{b: 8'hFF, s: 8'hFF, sm: 1'b0, acc: 1'b0, prod: 16'hFE01, x: 1'b0};

    rst_n = 1'b0; din = '0; loadB = 1'b0; run = 1'b0; signedMode = 1'b0; accum = 1'b0;
    #1;
    checkOutput("reset_product", {16'd0, product}, 32'd0);
    checkOutput("reset_flags", {29'd0, xval, busy, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; entry 1 accumulates onto A=0xFE left by entry 0.
    for (int i = 0; i < 6; i++) begin
      loadBReg(vecs[i].b);
      applyStimulus(vecs[i].s, vecs[i].sm, vecs[i].acc, vecs[i].prod, vecs[i].x, 1'b0, 1'b0, 0);
    end

    // Run held high past DONE, Load_B honoured while in DONE.
    loadBReg(8'h11);
    applyStimulus(8'h03, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0, 1'b0, 5);
    loadBReg(8'h05);
    checkOutput("loadb_idle", {24'd0, bval}, 32'h05);

    // Load_B with start plus disturbances during RUN: old B must be used.
    loadBReg(8'hC5);
    din = 8'h07;
    applyStimulus(8'h07, 1'b1, 1'b0, 16'hFE63, 1'b1, 1'b1, 1'b1, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    din = 8'h55; signedMode = 1'b0; accum = 1'b0; run = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_product", {16'd0, product}, 32'd0);
    checkOutput("midop_reset_flags", {29'd0, xval, busy, done}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mA = '0;
    mB = '0;

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      s   = W'($urandom);
      sm  = 1'($urandom);
      acc = 1'($urandom);
      if ($urandom_range(3) != 0) begin
        b = W'($urandom);
        loadBReg(b);
      end
      exp = modelProduct(mA, mB, s, sm, acc);
      applyStimulus(s, sm, acc, exp, sm ? exp[2*W-1] : 1'b0,
                    1'($urandom), 1'($urandom), int'($urandom_range(2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
